// File: rtl/cpu_core_mc.sv
// rtl/cpu_core_mc.sv - multi-cycle core for the 9-bit ISA with synchronous-read instruction/data ports
module cpu_core_mc #(
  parameter int DW = 8,
  parameter int PW = 12,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [PW-1:0] start_pc,
  output logic [PW-1:0] imem_addr,
  input  logic [8:0]    imem_rdata,
  output logic [DW-1:0] dmem_addr,
  output logic [DW-1:0] dmem_wdata,
  output logic          dmem_we,
  input  logic [DW-1:0] dmem_rdata,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] cycle_cnt
);

  typedef enum logic [2:0] {IDLE, FETCH, EXEC, MEM, DONE} state_t;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_SHL = 3'd3;
  localparam logic [2:0] OP_LDI = 3'd4;
  localparam logic [2:0] OP_MEM = 3'd5;
  localparam logic [2:0] OP_BR  = 3'd6;
  localparam logic [2:0] OP_MOV = 3'd7;

  state_t        state;
  logic [PW-1:0] pc;
  logic [DW-1:0] rf [8];
  logic          flag_c;
  logic          flag_z;
  logic          flag_l;
  logic [2:0]    ld_dst;

  logic [2:0]    op;
  logic [2:0]    fa;
  logic [2:0]    fb;
  logic [DW-1:0] ra;
  logic [DW-1:0] rb;
  logic [DW:0]   sum;
  logic [DW:0]   diff;
  logic [DW-1:0] and_res;
  logic [DW-1:0] shl_res;
  logic          is_halt;
  logic          br_taken;
  logic [PW-1:0] pc_inc;
  logic [PW-1:0] br_target;

  // Decode fields straight off the instruction port; only meaningful in EXEC.
  assign op        = imem_rdata[8:6];
  assign fa        = imem_rdata[5:3];
  assign fb        = imem_rdata[2:0];
  assign ra        = rf[fa];
  assign rb        = rf[fb];
  assign sum       = {1'b0, ra} + {1'b0, rb};
  assign diff      = {1'b0, ra} - {1'b0, rb};
  assign and_res   = ra & rb;
  assign shl_res   = {ra[DW-2:0], flag_c};
  assign is_halt   = (imem_rdata == 9'd0);
  assign br_taken  = fb[0] ? flag_l : ~flag_z;
  assign pc_inc    = pc + PW'(1);
  assign br_target = PW'(ra);

  assign imem_addr  = pc;
  assign dmem_addr  = rf[0];
  assign dmem_wdata = ra;
  // Store strobe depends on the word arriving in EXEC, so it cannot be registered.
  assign dmem_we    = (state == EXEC) && (op == OP_MEM) && fb[0];

  // Control FSM, register file, flags and run-cycle counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      pc        <= '0;
      flag_c    <= 1'b0;
      flag_z    <= 1'b0;
      flag_l    <= 1'b0;
      ld_dst    <= '0;
      cycle_cnt <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      for (int i = 0; i < 8; i++) rf[i] <= '0;
    end else begin
      if (busy && (cycle_cnt != '1)) cycle_cnt <= cycle_cnt + CW'(1);
      case (state)
        IDLE, DONE: begin
          if (start) begin
            pc        <= start_pc;
            cycle_cnt <= '0;
            busy      <= 1'b1;
            done      <= 1'b0;
            state     <= FETCH;
          end
        end
        FETCH: state <= EXEC;
        EXEC: begin
          state <= FETCH;
          pc    <= pc_inc;
          case (op)
            OP_ADD: begin
              if (is_halt) begin
                state <= DONE;
                pc    <= pc;
                busy  <= 1'b0;
                done  <= 1'b1;
              end else begin
                rf[fa] <= sum[DW-1:0];
                flag_c <= sum[DW];
                flag_z <= (sum[DW-1:0] == '0);
              end
            end
            OP_SUB: begin
              rf[fa] <= diff[DW-1:0];
              flag_c <= diff[DW];
              flag_z <= (diff[DW-1:0] == '0);
              flag_l <= (ra < rb);
            end
            OP_AND: begin
              rf[fa] <= and_res;
              flag_z <= (and_res == '0);
            end
            OP_SHL: begin
              rf[fa] <= shl_res;
              flag_c <= ra[DW-1];
            end
            OP_LDI: rf[0] <= DW'(imem_rdata[5:0]);
            OP_MEM: begin
              // Loads wait one cycle in MEM for the synchronous data port.
              if (!fb[0]) begin
                ld_dst <= fa;
                pc     <= pc;
                state  <= MEM;
              end
            end
            OP_BR:  pc <= br_taken ? br_target : pc_inc;
            OP_MOV: rf[fa] <= rb;
            default: ;
          endcase
        end
        MEM: begin
          rf[ld_dst] <= dmem_rdata;
          pc         <= pc_inc;
          state      <= FETCH;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/cpu_core_mc.md
Name: cpu_core_mc

Overview:
- Parametrised multi-cycle successor to the single-cycle 9-bit core.
- Data width and PC width are generic. Instruction and data memories sit outside the core and are reached through synchronous-read ports.
- A start/done handshake and a run-cycle counter let a testbench or host launch and time programs.
- Instantiated by the next top level beside instruction ROM and data memory.

Parameters:
DW, 8, data/register width (>=4)
PW, 12, program counter width
CW, 16, cycle counter width

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
start  input  1  launch program; sampled only in IDLE or DONE
start_pc  input  PW  first instruction address
imem_addr  output  PW  instruction address (= pc, combinational)
imem_rdata  input  9  instruction word, valid one cycle after imem_addr
dmem_addr  output  DW  data address (= R0)
dmem_wdata  output  DW  store data (= Ra)
dmem_we  output  1  store strobe, one cycle
dmem_rdata  input  DW  load data, valid one cycle after dmem_addr
busy  output  1  high in FETCH/EXEC/MEM
done  output  1  high in DONE
cycle_cnt  output  CW  cycles spent busy in current/last run

Behaviour:
- Register file: 8 x DW, R0..R7. Flags: C (carry), Z (zero), L (less-than).
- Instruction fields: op=[8:6], a=[5:3], b=[2:0]. An all-zero word is HALT.
- Opcodes:
  - 0 ADD: Ra<=Ra+Rb. C=carry-out, Z set. Exception: an all-zero word halts instead.
  - 1 SUB: Ra<=Ra-Rb. C=borrow, Z set, L=(Ra<Rb unsigned).
  - 2 AND: Ra<=Ra&Rb. Z set.
  - 3 SHL: Ra<={Ra[DW-2:0],C}; C<=Ra[DW-1]. b ignored.
  - 4 LDI: R0<=zero-extended instr[5:0].
  - 5 MEM: b[0]=0 is LD (Ra<=dmem[R0]); b[0]=1 is ST (dmem[R0]<=Ra).
  - 6 BR: b[0]=0 is BNZ; b[0]=1 is BLT.
    - Taken when Z==0 (BNZ) or L==1 (BLT).
    - Taken: pc<=Ra zero-extended/truncated to PW. Not taken: pc+1.
  - 7 MOV: Ra<=Rb.
- Flags change only where listed above.
- FSM states: IDLE, FETCH, EXEC, MEM, DONE.
  - IDLE: start=1 -> pc<=start_pc, cycle_cnt<=0, go to FETCH.
  - FETCH: imem_addr=pc -> EXEC.
  - EXEC: decode imem_rdata.
    - HALT -> DONE.
    - LD -> MEM.
    - ST: dmem_we=1 this cycle, pc<=pc+1 -> FETCH.
    - Else: write result/flags at clock edge, update pc -> FETCH.
  - MEM: Ra<=dmem_rdata, pc<=pc+1 -> FETCH.
  - DONE: done held high; start=1 behaves as in IDLE (relaunch).
- Cycle counts: ALU/LDI/MOV/BR/ST take 2 cycles, LD takes 3, HALT takes 2.
- pc+1 wraps modulo 2^PW.
- cycle_cnt increments every clock with busy=1 and saturates at 2^CW-1. It holds its value in DONE and is cleared on launch.
- start is ignored while busy.
- Reset is asynchronous and may arrive mid-instruction. It forces:
  - state=IDLE, pc=0, all registers 0, C/Z/L=0, cycle_cnt=0;
  - busy=0, done=0, dmem_we=0.
- No partial writes survive reset.
- dmem_we may be high only in EXEC of a ST.
- Writes to R0 by ALU ops are permitted.
- Register writes use arithmetic modulo 2^DW.

Test Plan:
- Reset during EXEC of ADD -> next cycle busy=0, R1 unchanged (0), dmem_we=0.
- start_pc=0; program LDI 5, MOV R1,R0, LDI 3, SUB R1,R0, HALT -> R1=2, L=0, C=0, done=1, cycle_cnt=10.
- ST then LD: R0=7, R2=0xA5; ST R2; LD R3 -> dmem_we pulses one cycle with addr 7, data 0xA5; R3=0xA5 after MEM; ST takes 2 cycles, LD 3.
- Countdown loop: R1=3, R2=1, R4=loop addr, SUB R1,R2, BNZ R4 -> body executes exactly 3 times, then falls through to HALT.
- PW=4, start_pc=15, instruction at 15 is MOV -> next imem_addr=0 (wrap).
- SHL with C=1, Ra=0x80 (DW=8) -> Ra=0x01, C=1. start pulsed while busy -> ignored, pc unaffected. start in DONE -> relaunch with cycle_cnt cleared.
